// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and command codes.
package spi_slave_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CHK_CMD   = 3'd1;
  localparam state_t ST_WRITE     = 3'd2;
  localparam state_t ST_READ_ADD  = 3'd3;
  localparam state_t ST_READ_DATA = 3'd4;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_WR_ADDR = 2'b00;
  localparam cmd_t CMD_WR_DATA = 2'b01;
  localparam cmd_t CMD_RD_ADDR = 2'b10;
  localparam cmd_t CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO parallel-to-serial shifter: loads a word and emits it MSB first, one bit per cycle.
module spi_tx_serializer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              miso
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] shreg_q;
  logic [CNT_W-1:0]  left_q;

  // MSB goes out the cycle after load; left_q counts the bits still queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso    <= 1'b0;
      shreg_q <= '0;
      left_q  <= '0;
    end else if (clear) begin
      miso    <= 1'b0;
      shreg_q <= '0;
      left_q  <= '0;
    end else if (load) begin
      miso    <= data[DATA_W-1];
      shreg_q <= {data[DATA_W-2:0], 1'b0};
      left_q  <= CNT_W'(DATA_W - 1);
    end else if (left_q != '0) begin
      miso    <= shreg_q[DATA_W-1];
      shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
      left_q  <= left_q - CNT_W'(1);
    end else begin
      miso    <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave frame receiver with read-data serializer.
// Optional macro SPI_SLAVE_FRAME_ERR_EN enables the frame_err pulse logic.
module spi_slave_gen
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TX_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned WAIT_W  = $clog2(TX_WAIT_MAX + 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [FRAME_W-2:0] shift_q;
  logic               read_flag_q;
  logic               waiting_q;
  logic [WAIT_W-1:0]  wait_cnt_q;

  logic abort_c;
  logic sample_c;
  logic last_c;
  logic load_c;
  logic timeout_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus per-cycle datapath strobes; SS_n high always wins
  always_comb begin
    state_d   = state_q;
    abort_c   = 1'b0;
    sample_c  = 1'b0;
    last_c    = 1'b0;
    load_c    = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!SS_n) state_d = ST_CHK_CMD;
      end
      ST_CHK_CMD: begin
        if (SS_n)            state_d = ST_IDLE;
        else if (!MOSI)      state_d = ST_WRITE;
        else if (read_flag_q) state_d = ST_READ_DATA;
        else                 state_d = ST_READ_ADD;
      end
      ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
        if (SS_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE) begin
      abort_c  = SS_n;
      sample_c = !SS_n && (bit_cnt_q != CNT_W'(FRAME_W));
      last_c   = sample_c && (bit_cnt_q == CNT_W'(FRAME_W - 1));
    end
    load_c    = waiting_q && !SS_n && tx_valid;
    timeout_c = waiting_q && !SS_n && !tx_valid
                && (wait_cnt_q == WAIT_W'(TX_WAIT_MAX - 1));
  end

  // Frame shift/count, rx handoff, read_flag and tx_valid wait window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      read_flag_q <= 1'b0;
      waiting_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (abort_c) begin
        bit_cnt_q  <= '0;
        shift_q    <= '0;
        waiting_q  <= 1'b0;
        wait_cnt_q <= '0;
      end else begin
        if (sample_c) begin
          shift_q   <= {shift_q[FRAME_W-3:0], MOSI};
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
        if (last_c) begin
          rx_data  <= {shift_q, MOSI};
          rx_valid <= 1'b1;
          if (state_q == ST_READ_ADD)  read_flag_q <= 1'b1;
          if (state_q == ST_READ_DATA) read_flag_q <= 1'b0;
        end
        // Wait window opens the cycle after the rx_valid pulse
        if (rx_valid && (state_q == ST_READ_DATA)) begin
          waiting_q  <= 1'b1;
          wait_cnt_q <= '0;
        end else if (load_c || timeout_c) begin
          waiting_q  <= 1'b0;
        end else if (waiting_q) begin
          wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= (abort_c && (bit_cnt_q != CNT_W'(FRAME_W))) || timeout_c;
  end
`else
  assign frame_err = 1'b0;
`endif

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (abort_c),
    .load  (load_c),
    .data  (tx_data),
    .miso  (MISO)
  );

endmodule

// File: tb/tb_spi_slave_gen.sv
// Self-checking bench for spi_slave_gen (DATA_W=8, TX_WAIT_MAX=15): directed and random frames.
module tb_spi_slave_gen;
  import spi_slave_pkg::*;

  localparam int DATA_W      = 8;
  localparam int TX_WAIT_MAX = 15;
  localparam int FRAME_W     = DATA_W + 2;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              SS_n;
  logic              MOSI;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;

  int ncmp = 0;
  int nerr = 0;
  bit rf   = 1'b0;

  logic              mo [64];
  logic              tv [64];
  logic [DATA_W-1:0] td [64];

  always #5 clk = ~clk;

  spi_slave_gen #(.DATA_W(DATA_W), .TX_WAIT_MAX(TX_WAIT_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .MISO      (MISO),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      mo[i] = 1'($urandom);
      tv[i] = 1'b0;
      td[i] = DATA_W'($urandom);
    end
  endtask

  task automatic set_bits(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) mo[i] = v[n-1-i];
  endtask

  // One SS_n-low window of len cycles after the select cycle, then one deselect cycle.
  task automatic run_frame(input int len, input int rst_at);
    bit                rd;
    bit                done;
    int                t;
    logic [FRAME_W-1:0] exp_rx;
    logic [DATA_W-1:0] word;
    logic              exp_miso;
    rd   = (mo[0] === 1'b1) && rf;
    done = (len >= FRAME_W);
    for (int i = 0; i < FRAME_W; i++) exp_rx[FRAME_W-1-i] = mo[i];
    t = -1;
    if (rd && done)
      for (int c = FRAME_W + 1; c <= FRAME_W + TX_WAIT_MAX && c < len; c++)
        if (tv[c] && t < 0) t = c;

    SS_n = 1'b0; MOSI = 1'($urandom); tx_valid = 1'($urandom); tx_data = DATA_W'($urandom);
    @(negedge clk);
    check("select_rx_valid", 32'(rx_valid), 32'(0));
    check("select_state", 32'(dut.state_q), 32'(ST_CHK_CMD));

    for (int c = 0; c < len; c++) begin
      SS_n = 1'b0; MOSI = mo[c]; tx_valid = tv[c]; tx_data = td[c];
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_miso", 32'(MISO), 32'(0));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        check("rst_rx_data", 32'(rx_data), 32'(0));
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("rst_read_flag", 32'(dut.read_flag_q), 32'(0));
        @(negedge clk);
        SS_n = 1'b1; rst_n = 1'b1; rf = 1'b0;
        @(negedge clk);
        check("post_rst_miso", 32'(MISO), 32'(0));
        return;
      end
      @(negedge clk);
      check("rx_valid", 32'(rx_valid), 32'(c == FRAME_W - 1));
      if (c == FRAME_W - 1) check("rx_data", 32'(rx_data), 32'(exp_rx));
      exp_miso = 1'b0;
      if (t >= 0 && c >= t && c < t + DATA_W) begin
        word     = td[t];
        exp_miso = word[DATA_W-1-(c-t)];
      end
      check("miso", 32'(MISO), 32'(exp_miso));
      check("frame_err", 32'(frame_err),
            32'(ERR_EN && rd && done && t < 0 && c == FRAME_W + TX_WAIT_MAX));
    end

    SS_n = 1'b1; MOSI = 1'($urandom); tx_valid = 1'($urandom); tx_data = DATA_W'($urandom);
    @(negedge clk);
    check("deselect_frame_err", 32'(frame_err), 32'(ERR_EN && !done));
    check("deselect_rx_valid", 32'(rx_valid), 32'(0));
    check("deselect_miso", 32'(MISO), 32'(0));
    check("deselect_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    check("idle_frame_err", 32'(frame_err), 32'(0));
    if (done && mo[0] === 1'b1) rf = !rf;
    check("read_flag", 32'(dut.read_flag_q), 32'(rf));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(MISO), 32'(0));
    check("reset_rx_data", 32'(rx_data), 32'(0));
    check("reset_rx_valid", 32'(rx_valid), 32'(0));
    check("reset_frame_err", 32'(frame_err), 32'(0));
    check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Write frame 00_1010_0101
    clear_stim(); set_bits({2'b00, CMD_WR_ADDR, DATA_W'(8'hA5)}, FRAME_W); run_frame(FRAME_W, -1);

    // Read address then read data with 0xC3; early and mid-shift tx_valid ignored
    clear_stim(); set_bits({2'b00, CMD_RD_ADDR, DATA_W'(8'h03)}, FRAME_W); run_frame(FRAME_W, -1);
    clear_stim(); set_bits({2'b00, CMD_RD_DATA, DATA_W'(8'h5A)}, FRAME_W);
    tv[5] = 1'b1; td[5] = 8'h00;
    tv[10] = 1'b1; td[10] = 8'h81;
    tv[12] = 1'b1; td[12] = 8'hC3;
    tv[15] = 1'b1; td[15] = 8'h00;
    run_frame(26, -1);

    // Aborted frame after 5 bits
    clear_stim(); run_frame(5, -1);

    // Reset in the middle of shifting out 0xFF
    clear_stim(); set_bits({2'b00, CMD_RD_ADDR, DATA_W'(8'h11)}, FRAME_W); run_frame(FRAME_W, -1);
    clear_stim(); set_bits({2'b00, CMD_RD_DATA, DATA_W'(8'h22)}, FRAME_W);
    tv[11] = 1'b1; td[11] = 8'hFF;
    run_frame(30, 15);

    // Read data with tx_valid only after the wait window closes
    clear_stim(); set_bits({2'b00, CMD_RD_ADDR, DATA_W'(8'h44)}, FRAME_W); run_frame(FRAME_W, -1);
    clear_stim(); set_bits({2'b00, CMD_RD_DATA, DATA_W'(8'h00)}, FRAME_W);
    tv[26] = 1'b1; td[26] = 8'hFF;
    tv[28] = 1'b1; td[28] = 8'hAA;
    run_frame(32, -1);

    // Twelve bits in one write frame
    clear_stim(); set_bits({2'b00, CMD_WR_DATA, DATA_W'(8'h96)}, FRAME_W);
    mo[10] = 1'b1; mo[11] = 1'b0;
    run_frame(12, -1);

    // Random frames of random length and tx_valid patterns
    for (int f = 0; f < 30; f++) begin
      clear_stim();
      for (int i = 0; i < 64; i++) tv[i] = ($urandom_range(5, 0) == 0);
      if ($urandom_range(2, 0) != 0) mo[0] = 1'b1;
      if ($urandom_range(1, 0) == 0) len = $urandom_range(34, 1);
      else                           len = $urandom_range(34, FRAME_W);
      run_frame(len, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/spi_slave_gen.md
SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload width in bits (min 4); rx frame width is DATA_W+2.
REQ-002 SHALL have parameter TX_WAIT_MAX, default 15, meaning max cycles to wait for tx_valid in READ_DATA (min 1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port SS_n  input  1  slave select, active low.
REQ-006 SHALL have port MOSI  input  1  serial data in, sampled on clk rising edge.
REQ-007 SHALL have port tx_data  input  DATA_W  read payload from memory.
REQ-008 SHALL have port tx_valid  input  1  tx_data valid strobe.
REQ-009 SHALL have port MISO  output  1  serial data out, MSB first.
REQ-010 SHALL have port rx_data  output  DATA_W+2  {cmd[1:0], payload}.
REQ-011 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on aborted frame or tx timeout.

Function
REQ-013 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-014 SHALL go IDLE->CHK_CMD when SS_n=0; otherwise stay in IDLE.
REQ-015 SHALL leave CHK_CMD for WRITE if MOSI=0, READ_ADD if MOSI=1 and read_flag=0, READ_DATA if MOSI=1 and read_flag=1, IDLE if SS_n=1.
REQ-016 SHALL capture the MOSI bit sampled in CHK_CMD as rx_data MSB, then shift DATA_W+1 further bits MSB-first in WRITE/READ_ADD/READ_DATA.
REQ-017 SHALL update rx_data and pulse rx_valid for exactly one cycle in the cycle after the last (DATA_W+2)th bit is sampled.
REQ-018 SHALL ignore MOSI bits beyond DATA_W+2 until SS_n rises; no second rx_valid in the same frame.
REQ-019 SHALL set the internal read_flag on rx_valid in READ_ADD and clear it on rx_valid in READ_DATA; WRITE frames leave it unchanged.
REQ-020 SHALL, in READ_DATA after rx_valid, latch tx_data on the first cycle tx_valid=1, then drive MISO with bit DATA_W-1 down to 0, one bit per cycle, starting the next cycle.
REQ-021 SHALL hold MISO at 0 whenever not serializing.
REQ-022 SHALL ignore tx_valid outside READ_DATA and while serializing.
REQ-023 SHALL, on SS_n=1 in any non-IDLE state, go to IDLE next cycle, clear bit counter and serializer, and suppress a pending rx_valid.
REQ-024 SHALL give SS_n rise priority over a simultaneous frame completion or tx_valid.
REQ-025 SHALL, if tx_valid is absent for TX_WAIT_MAX cycles after rx_valid in READ_DATA, stop waiting, keep MISO 0, and stay in READ_DATA until SS_n=1.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously force state IDLE, rx_data 0, rx_valid 0, MISO 0, frame_err 0, read_flag 0, counters 0.
REQ-027 SHALL, on reset asserted mid-frame, discard the partial frame with no rx_valid or frame_err.

Configuration
REQ-028 SHALL, with macro SPI_SLAVE_FRAME_ERR_EN defined, pulse frame_err one cycle on SS_n rise before DATA_W+2 bits, or on tx timeout (REQ-025).
REQ-029 SHALL, without SPI_SLAVE_FRAME_ERR_EN, tie frame_err to 0 and omit its logic; all other behaviour identical.

Structure
REQ-030 SHALL take state encoding typedef and command codes (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data) from shared package spi_slave_pkg.
REQ-031 SHALL place MISO parallel-to-serial logic in sub-module spi_tx_serializer (parameter DATA_W).

Verification (DATA_W=8)
REQ-032 SHALL test: SS_n low, MOSI 00_1010_0101, SS_n high -> rx_data=0x0A5, rx_valid single pulse, read_flag unchanged.
REQ-033 SHALL test: frame 10_0000_0011 then frame 11_xxxx_xxxx, tx_valid with tx_data=0xC3 -> MISO 1,1,0,0,0,0,1,1 over 8 cycles, read_flag 0 after.
REQ-034 SHALL test: SS_n high after 5 bits -> IDLE next cycle, no rx_valid, frame_err=1 one cycle (macro on) / 0 (macro off).
REQ-035 SHALL test: rst_n low mid-serialization of 0xFF -> MISO 0 immediately, state IDLE, outputs 0.
REQ-036 SHALL test: rd-data frame with no tx_valid for 15 cycles -> MISO stays 0, frame_err pulse (macro on), late tx_valid ignored.
REQ-037 SHALL test: 12 MOSI bits in one frame -> exactly one rx_valid, rx_data from first 10 bits.
